// File: rtl/adsr_envelope_pkg.sv
// Shared constants and state encoding for the ADSR envelope generator.
package adsr_envelope_pkg;

    localparam int unsigned ENV_WIDTH   = 16;
    localparam int unsigned SYNTH_WIDTH = 16;

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

endpackage : adsr_envelope_pkg

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: tick-driven level FSM plus one registered
// multiply stage that scales the oscillator sample by the current level.
module adsr_envelope
    import adsr_envelope_pkg::*;
(
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          sample_valid_in,
    input  logic signed [SYNTH_WIDTH-1:0] synth_in,
    input  logic                          gate_in,
    input  logic        [ENV_WIDTH-1:0]   attack_step_in,
    input  logic        [ENV_WIDTH-1:0]   decay_step_in,
    input  logic        [ENV_WIDTH-1:0]   sustain_level_in,
    input  logic        [ENV_WIDTH-1:0]   release_step_in,
    output logic signed [SYNTH_WIDTH-1:0] audio_out,
    output logic                          audio_valid_out,
    output logic        [ENV_WIDTH-1:0]   env_out,
    output logic        [2:0]             state_out
);

    env_state_t                    state_q, state_d;
    logic        [ENV_WIDTH-1:0]   env_q, env_d;
    logic                          gate_prev_q, gate_prev_d;
    logic signed [SYNTH_WIDTH-1:0] audio_q, audio_d;
    logic                          audio_valid_q, audio_valid_d;

    logic                                rise;
    logic        [ENV_WIDTH:0]           attack_sum;
    logic        [ENV_WIDTH-1:0]         decay_room;
    logic signed [SYNTH_WIDTH+ENV_WIDTH:0] product;
    logic signed [SYNTH_WIDTH+ENV_WIDTH:0] product_shr;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            env_q       <= '0;
            gate_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            env_q       <= env_d;
            gate_prev_q <= gate_prev_d;
        end
    end

    // Next-state and level computation
    always_comb begin
        state_d     = state_q;
        env_d       = env_q;
        gate_prev_d = gate_prev_q;
        rise        = gate_in & ~gate_prev_q;
        attack_sum  = {1'b0, env_q} + {1'b0, attack_step_in};
        decay_room  = env_q - sustain_level_in;

        if (sample_valid_in) begin
            gate_prev_d = gate_in;
            // Retrigger keeps the current level so a re-gate in RELEASE ramps from there.
            if (rise) begin
                state_d = ST_ATTACK;
            end else if (!gate_in && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                                      state_q == ST_SUSTAIN)) begin
                state_d = ST_RELEASE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        env_d = '0;
                    end
                    ST_ATTACK: begin
                        if (attack_sum >= {1'b0, ENV_MAX}) begin
                            env_d   = ENV_MAX;
                            state_d = ST_DECAY;
                        end else begin
                            env_d = attack_sum[ENV_WIDTH-1:0];
                        end
                    end
                    ST_DECAY: begin
                        if (env_q <= sustain_level_in || decay_step_in >= decay_room) begin
                            env_d   = sustain_level_in;
                            state_d = ST_SUSTAIN;
                        end else begin
                            env_d = env_q - decay_step_in;
                        end
                    end
                    ST_SUSTAIN: begin
                        env_d = sustain_level_in;
                    end
                    ST_RELEASE: begin
                        if (release_step_in >= env_q) begin
                            env_d   = '0;
                            state_d = ST_IDLE;
                        end else begin
                            env_d = env_q - release_step_in;
                        end
                    end
                    default: begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Scaling stage uses the pre-update level of the same tick
    always_comb begin
        product       = synth_in * $signed({1'b0, env_q});
        product_shr   = product >>> ENV_WIDTH;
        audio_d       = audio_q;
        audio_valid_d = sample_valid_in;
        if (sample_valid_in) begin
            audio_d = $signed(product_shr[SYNTH_WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            audio_q       <= '0;
            audio_valid_q <= 1'b0;
        end else begin
            audio_q       <= audio_d;
            audio_valid_q <= audio_valid_d;
        end
    end

    // Outputs
    always_comb begin
        audio_out       = audio_q;
        audio_valid_out = audio_valid_q;
        env_out         = env_q;
        state_out       = state_q;
    end

endmodule : adsr_envelope

// File: doc/adsr_envelope.md
ADSR_ENVELOPE -- requirements
Module: adsr_envelope

Interface
REQ-001 clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-002 rst_in  input  1  asynchronous reset, active-high.
REQ-003 sample_valid_in  input  1  one-cycle sample tick; envelope and gate are evaluated only on tick cycles.
REQ-004 synth_in  input  signed SYNTH_WIDTH  oscillator sample, valid on tick cycles.
REQ-005 gate_in  input  1  note held (1) or released (0).
REQ-006 attack_step_in  input  ENV_WIDTH  unsigned increment per tick in ATTACK.
REQ-007 decay_step_in  input  ENV_WIDTH  unsigned decrement per tick in DECAY.
REQ-008 sustain_level_in  input  ENV_WIDTH  unsigned sustain target.
REQ-009 release_step_in  input  ENV_WIDTH  unsigned decrement per tick in RELEASE.
REQ-010 audio_out  output  signed SYNTH_WIDTH  registered, envelope-scaled sample.
REQ-011 audio_valid_out  output  1  one-cycle strobe qualifying audio_out.
REQ-012 env_out  output  ENV_WIDTH  current envelope level, registered.
REQ-013 state_out  output  3  current env_state_t encoding.

Function
REQ-014 States: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE; state, env and gate_prev change only on tick cycles.
REQ-015 gate_prev is loaded with gate_in on every tick; rise = gate_in & ~gate_prev, evaluated at the tick.
REQ-016 On a rise from any state, go to ATTACK; env keeps its current value (no retrigger to 0).
REQ-017 ATTACK: env = min(env + attack_step_in, ENV_MAX), computed without overflow; on reaching ENV_MAX, go to DECAY.
REQ-018 DECAY: env = max(env - decay_step_in, sustain_level_in), with no underflow; on reaching sustain_level_in, go to SUSTAIN.
REQ-019 DECAY entered with env <= sustain_level_in: env takes sustain_level_in on that tick; go to SUSTAIN.
REQ-020 SUSTAIN: env tracks sustain_level_in on each tick.
REQ-021 gate_in=0 at a tick in ATTACK, DECAY or SUSTAIN: go to RELEASE. That tick's level update is skipped; env is held.
REQ-022 RELEASE: env = max(env - release_step_in, 0); on reaching 0, go to IDLE.
REQ-023 IDLE: env = 0.
REQ-024 Priority at a tick: rise > gate low > normal progression.
REQ-025 A step of 0 holds env and the state indefinitely; this is legal, not an error.
REQ-026 Scaling on a tick: product = synth_in * signed'({1'b0, env}), using env before that tick's update.
REQ-027 audio_out = product >>> ENV_WIDTH (arithmetic, truncated to SYNTH_WIDTH); registered with 1-cycle latency.
REQ-028 audio_valid_out pulses exactly one cycle after each tick; back-to-back ticks give back-to-back strobes.
REQ-029 audio_out holds its value between strobes.

Reset
REQ-030 rst_in=1 forces, immediately and asynchronously: state IDLE, env_out 0, gate_prev 0, audio_out 0, audio_valid_out 0, state_out IDLE.
REQ-031 Reset asserted mid-envelope or mid-strobe discards all progress; the first tick after release of reset behaves as from IDLE.

Structure
REQ-032 ENV_WIDTH (16), ENV_MAX (all ones) and env_state_t belong in the shared constants package; SYNTH_WIDTH is reused from it.
REQ-033 No sub-module is required: one FSM/level process plus one registered multiply stage.

Verification (SYNTH_WIDTH=16, ENV_WIDTH=16)
REQ-034 Sequence: gate high; attack_step=0x4000; decay_step=0x1000; sustain=0x8000; ticks every 4 cycles. Expect env 0x4000, 0x8000, 0xC000, 0xFFFF (ATTACK). Then DECAY 0xEFFF down to 0x8000, then SUSTAIN.
REQ-035 From SUSTAIN 0x8000, drop gate with release_step=0x3000. Expect env held 0x8000 (RELEASE entered), then 0x5000, 0x2000, 0x0000. Then IDLE.
REQ-036 Regate in RELEASE at env=0x5000 with attack_step=0x4000. Expect ATTACK, then env 0x9000; no reset to 0.
REQ-037 Scaling: synth_in=-32768 with env 0x8000 -> audio_out=-16384. synth_in=32767 with env 0 -> audio_out 0. audio_valid_out is exactly one cycle after each tick.
REQ-038 Assert rst_in asynchronously mid-DECAY between clock edges. Expect env_out=0, IDLE and audio_valid_out=0 before the next edge. Also check step=0 stalls ATTACK at 0.
